// File: rtl/axis_apb_master.sv
// Byte-stream to APB3 bridge: parses opcode/address/data command frames from an
// AXIS byte input, runs one APB transaction as bus master, then streams a
// status (and, for reads, prdata) response frame out on an AXIS byte output.
module axis_apb_master #(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [7:0]                s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  output logic [7:0]                m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [APB_ADDR_WIDTH-1:0] paddr,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [APB_DATA_WIDTH-1:0] pwdata,
  input  logic [APB_DATA_WIDTH-1:0] prdata,
  input  logic                      pready,
  input  logic                      pslverr
);

  localparam int          AB     = int'(APB_ADDR_WIDTH / 8);
  localparam int          DB     = int'(APB_DATA_WIDTH / 8);
  localparam int          CNT_W  = $clog2(AB + DB + 2);
  localparam int          TO_W   = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam int unsigned RESP_W = APB_DATA_WIDTH + 8;

  localparam logic [7:0] OPC_WR = 8'h01;
  localparam logic [7:0] OPC_RD = 8'h02;
  localparam logic [7:0] ST_OK  = 8'h00;
  localparam logic [7:0] ST_ERR = 8'h01;
  localparam logic [7:0] ST_TMO = 8'h02;
  localparam logic [7:0] ST_BAD = 8'hFE;

  localparam logic [CNT_W-1:0] ADDR_LAST    = CNT_W'(AB - 1);
  localparam logic [CNT_W-1:0] DATA_LAST    = CNT_W'(DB - 1);
  localparam logic [CNT_W-1:0] RD_RESP_LAST = CNT_W'(DB);
  // Last ACCESS cycle index before the timeout fires (count reaches the limit).
  localparam logic [TO_W-1:0]  TO_LAST      = TO_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_OPC,
    S_ADDR,
    S_DATA,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    byte_idx;
  logic [CNT_W-1:0]    resp_last;
  logic [TO_W-1:0]     to_cnt;
  logic [RESP_W-1:0]   resp_sr;
  logic                cmd_hs;
  logic                resp_hs;
  logic                opc_valid;
  logic                timeout_hit;

  assign cmd_hs      = s_axis_tvalid & s_axis_tready;
  assign resp_hs     = m_axis_tvalid & m_axis_tready;
  assign opc_valid   = (s_axis_tdata == OPC_WR) || (s_axis_tdata == OPC_RD);
  // pready in the limit cycle takes priority, so the timeout needs !pready.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && !pready && (to_cnt == TO_LAST);

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) state <= S_OPC;
    else         state <= state_nxt;
  end

  // Next-state decode and handshake/APB control outputs.
  always_comb begin
    state_nxt     = state;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = 8'h00;
    psel          = 1'b0;
    penable       = 1'b0;
    case (state)
      S_OPC: begin
        s_axis_tready = rstn_i;
        if (s_axis_tvalid) state_nxt = opc_valid ? S_ADDR : S_RESP;
      end
      S_ADDR: begin
        s_axis_tready = rstn_i;
        if (s_axis_tvalid && (byte_idx == ADDR_LAST)) state_nxt = pwrite ? S_DATA : S_SETUP;
      end
      S_DATA: begin
        s_axis_tready = rstn_i;
        if (s_axis_tvalid && (byte_idx == DATA_LAST)) state_nxt = S_SETUP;
      end
      S_SETUP: begin
        psel      = 1'b1;
        state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (pready || timeout_hit) state_nxt = S_RESP;
      end
      S_RESP: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = resp_sr[7:0];
        if (m_axis_tready && (byte_idx == resp_last)) state_nxt = S_OPC;
      end
      default: state_nxt = S_OPC;
    endcase
  end

  // Frame byte index, timeout counter and the APB address/data/direction registers.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      byte_idx  <= '0;
      resp_last <= '0;
      to_cnt    <= '0;
      paddr     <= '0;
      pwdata    <= '0;
      pwrite    <= 1'b0;
    end else begin
      case (state)
        S_OPC: begin
          if (cmd_hs) begin
            byte_idx  <= '0;
            resp_last <= '0;
            if (s_axis_tdata == OPC_WR) begin
              pwrite <= 1'b1;
            end else if (s_axis_tdata == OPC_RD) begin
              pwrite <= 1'b0;
              pwdata <= '0;
            end
          end
        end
        S_ADDR: begin
          if (cmd_hs) begin
            for (int i = 0; i < AB; i++) begin
              if (byte_idx == CNT_W'(i)) paddr[8*i +: 8] <= s_axis_tdata;
            end
            byte_idx <= (byte_idx == ADDR_LAST) ? '0 : byte_idx + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (cmd_hs) begin
            for (int i = 0; i < DB; i++) begin
              if (byte_idx == CNT_W'(i)) pwdata[8*i +: 8] <= s_axis_tdata;
            end
            byte_idx <= (byte_idx == DATA_LAST) ? '0 : byte_idx + CNT_W'(1);
          end
        end
        S_SETUP: to_cnt <= '0;
        S_ACCESS: begin
          to_cnt <= to_cnt + TO_W'(1);
          if (pready) begin
            byte_idx  <= '0;
            resp_last <= pwrite ? '0 : RD_RESP_LAST;
          end else if (timeout_hit) begin
            byte_idx  <= '0;
            resp_last <= '0;
          end
        end
        S_RESP: if (resp_hs) byte_idx <= byte_idx + CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Response shift register: status in the low byte, prdata above it, shifted out LSB first.
  always_ff @(posedge clk_i) begin
    case (state)
      S_OPC: if (cmd_hs && !opc_valid) resp_sr <= {{APB_DATA_WIDTH{1'b0}}, ST_BAD};
      S_ACCESS: begin
        if (pready)           resp_sr <= {prdata, pslverr ? ST_ERR : ST_OK};
        else if (timeout_hit) resp_sr <= {{APB_DATA_WIDTH{1'b0}}, ST_TMO};
      end
      S_RESP: if (resp_hs) resp_sr <= resp_sr >> 8;
      default: ;
    endcase
  end

endmodule
